// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-BRAM command bridge: opcodes, FSM state
// encodings and the byte-count helpers used to size the datapath.
package spi_bridge_pkg;

  // Command opcodes carried in byte 0 of a frame.
  localparam logic [7:0] OpWrite  = 8'h01;
  localparam logic [7:0] OpRead   = 8'h02;
  localparam logic [7:0] OpStatus = 8'h03;
  localparam logic [7:0] OpClrErr = 8'h04;

  // Encodings are visible on the state port and in the STATUS byte.
  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StOpc    = 4'd1,
    StAddr   = 4'd2,
    StLen    = 4'd3,
    StWdata  = 4'd4,
    StRfetch = 4'd5,
    StRdata  = 4'd6,
    StStat   = 4'd7,
    StDrain  = 4'd8,
    StWcsum  = 4'd9,
    StRcsum  = 4'd10
  } state_e;

  // Bytes per memory word.
  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Address bytes in a header, ceil(addr_w / 8).
  function automatic int unsigned addr_bytes(input int unsigned addr_w);
    return (addr_w + 7) / 8;
  endfunction

endpackage

// File: rtl/spi_bridge_word_pack.sv
// Byte/word converter for the SPI bridge. One shift register and one byte
// counter serve both directions: bytes pushed in MSB first assemble a word,
// and a loaded word is popped out MSB first. Never pushed and popped at once.
module spi_bridge_word_pack
  import spi_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [7:0]        i_byte,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_last,
  output logic [7:0]        o_byte,
  output logic              o_byte_last
);

  localparam int unsigned BYTES = bytes_of(DATA_W);

  logic [DATA_W-1:0] r_shift;
  logic [3:0]        r_cnt;
  logic              w_cnt_last;

  assign w_cnt_last  = (r_cnt == 4'(BYTES - 1));
  // Word including the byte being pushed this cycle, so a completed word
  // can be registered straight into the write port.
  assign o_word      = DATA_W'({r_shift, i_byte});
  assign o_word_last = w_cnt_last;
  assign o_byte      = r_shift[DATA_W-1 -: 8];
  assign o_byte_last = w_cnt_last;

  // Shift register and byte counter; clear discards any partial word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
    end else if (i_push) begin
      r_shift <= o_word;
      r_cnt   <= w_cnt_last ? 4'd0 : r_cnt + 4'd1;
    end else if (i_pop) begin
      r_shift <= r_shift << 8;
      r_cnt   <= w_cnt_last ? 4'd0 : r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// Byte-stream command engine between an SPI slave and dual-port BRAMs.
// Decodes opcode/address/length headers, runs burst writes and reads with
// address auto-increment, and reports a sticky error flag.
// Optional build macro SPI_BRIDGE_CSUM_EN adds an XOR checksum byte to the
// end of WRITE (checked) and READ (generated) bursts.
module spi_mem_bridge
  import spi_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err,
  output logic [3:0]        state
);

  localparam int unsigned AB = addr_bytes(ADDR_W);

`ifdef SPI_BRIDGE_CSUM_EN
  localparam state_e StWrDone = StWcsum;
  localparam state_e StRdDone = StRcsum;
`else
  localparam state_e StWrDone = StDrain;
  localparam state_e StRdDone = StDrain;
`endif

  state_e            r_state, w_state_d;
  logic [7:0]        r_opc, r_stat, r_len;
  logic [1:0]        r_abcnt, r_wait;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic              r_mem_we, r_mem_re;
  logic [ADDR_W-1:0] r_mem_waddr, r_mem_raddr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_opc_cap, w_addr_shift, w_len_cap;
  logic              w_push, w_pop, w_load, w_word_done, w_re_set;
  logic              w_err_set, w_err_clr, w_pack_clr;
  logic [DATA_W-1:0] w_pk_word;
  logic              w_pk_word_last, w_ser_last;
  logic [7:0]        w_ser_byte;

`ifdef SPI_BRIDGE_CSUM_EN
  logic [7:0]        r_csum;
`endif

  // A dropped chip select or an idle FSM discards any partial word.
  assign w_pack_clr = cs_n || (r_state == StIdle);

  spi_bridge_word_pack #(
    .DATA_W (DATA_W)
  ) u_word_pack (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr       (w_pack_clr),
    .i_push      (w_push),
    .i_byte      (rx_data),
    .i_load      (w_load),
    .i_word      (mem_rdata),
    .i_pop       (w_pop),
    .o_word      (w_pk_word),
    .o_word_last (w_pk_word_last),
    .o_byte      (w_ser_byte),
    .o_byte_last (w_ser_last)
  );

  // Next-state and datapath strobes; cs_n high overrides everything.
  always_comb begin
    w_state_d    = r_state;
    w_opc_cap    = 1'b0;
    w_addr_shift = 1'b0;
    w_len_cap    = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_word_done  = 1'b0;
    w_re_set     = 1'b0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    if (cs_n) begin
      w_state_d = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (rx_valid) begin
            w_opc_cap = 1'b1;
            w_state_d = StOpc;
          end
        end
        StOpc: begin
          case (r_opc)
            OpWrite, OpRead: w_state_d = StAddr;
            OpStatus:        w_state_d = StStat;
            OpClrErr: begin
              w_err_clr = 1'b1;
              w_state_d = StDrain;
            end
            default: begin
              w_err_set = 1'b1;
              w_state_d = StDrain;
            end
          endcase
        end
        StAddr: begin
          if (rx_valid) begin
            w_addr_shift = 1'b1;
            if (r_abcnt == 2'(AB - 1)) w_state_d = StLen;
          end
        end
        StLen: begin
          if (rx_valid) begin
            w_len_cap = 1'b1;
            if (r_opc == OpRead) begin
              w_re_set  = 1'b1;
              w_state_d = StRfetch;
            end else begin
              w_state_d = StWdata;
            end
          end
        end
        StWdata: begin
          if (rx_valid) begin
            w_push = 1'b1;
            if (w_pk_word_last) begin
              w_word_done = 1'b1;
              if (r_len == 8'd0) w_state_d = StWrDone;
            end
          end
        end
        StRfetch: begin
          if (r_wait == 2'(RD_LAT)) begin
            w_load    = 1'b1;
            w_state_d = StRdata;
          end
        end
        StRdata: begin
          if (tx_ready) begin
            w_pop = 1'b1;
            if (w_ser_last) begin
              w_word_done = 1'b1;
              if (r_len == 8'd0) begin
                w_state_d = StRdDone;
              end else begin
                w_re_set  = 1'b1;
                w_state_d = StRfetch;
              end
            end
          end
        end
        StStat: begin
          if (tx_ready) w_state_d = StDrain;
        end
`ifdef SPI_BRIDGE_CSUM_EN
        StWcsum: begin
          if (rx_valid) begin
            if (rx_data != r_csum) w_err_set = 1'b1;
            w_state_d = StDrain;
          end
        end
        StRcsum: begin
          if (tx_ready) w_state_d = StDrain;
        end
`endif
        StDrain: w_state_d = StDrain;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Header capture, address/length counters, memory strobes and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opc       <= '0;
      r_stat      <= '0;
      r_len       <= '0;
      r_abcnt     <= '0;
      r_wait      <= '0;
      r_addr      <= '0;
      r_err       <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_mem_re    <= 1'b0;
      r_mem_raddr <= '0;
    end else begin
      if (w_opc_cap) begin
        r_opc   <= rx_data;
        // STATUS reports the flags as they stood when the opcode arrived.
        r_stat  <= {r_err, 3'b000, r_state};
        r_abcnt <= '0;
      end
      // Upper unused address bits fall off the top of the shift.
      if (w_addr_shift) begin
        r_addr  <= ADDR_W'({r_addr, rx_data});
        r_abcnt <= r_abcnt + 2'd1;
      end
      if (w_word_done) r_addr <= r_addr + ADDR_W'(1);
      if (w_len_cap) begin
        r_len <= rx_data;
      end else if (w_word_done && (r_len != 8'd0)) begin
        r_len <= r_len - 8'd1;
      end
      r_mem_we <= w_push && w_pk_word_last;
      if (w_push && w_pk_word_last) begin
        r_mem_waddr <= r_addr;
        r_mem_wdata <= w_pk_word;
      end
      r_mem_re <= w_re_set;
      if (w_re_set) begin
        r_mem_raddr <= w_word_done ? r_addr + ADDR_W'(1) : r_addr;
        r_wait      <= '0;
      end else if (r_state == StRfetch) begin
        r_wait <= r_wait + 2'd1;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

`ifdef SPI_BRIDGE_CSUM_EN
  // Running XOR of data bytes received (WRITE) or shifted out (READ).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum <= '0;
    end else if (w_opc_cap) begin
      r_csum <= '0;
    end else if (w_push) begin
      r_csum <= r_csum ^ rx_data;
    end else if (w_pop) begin
      r_csum <= r_csum ^ w_ser_byte;
    end
  end
`endif

  // Transmit byte source; tx_data is held at zero when nothing is offered.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      StRdata: begin
        tx_valid = 1'b1;
        tx_data  = w_ser_byte;
      end
      StStat: begin
        tx_valid = 1'b1;
        tx_data  = r_stat;
      end
`ifdef SPI_BRIDGE_CSUM_EN
      StRcsum: begin
        tx_valid = 1'b1;
        tx_data  = r_csum;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  assign mem_we    = r_mem_we;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign mem_re    = r_mem_re;
  assign mem_raddr = r_mem_raddr;
  assign busy      = (r_state != StIdle);
  assign err       = r_err;
  assign state     = r_state;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge (DATA_W=32, ADDR_W=10, RD_LAT=1).
// A table of whole frames with expected memory strobes, tx bytes and error
// flag, followed by hand-written abort, cs_n/rx_valid collision and
// asynchronous-reset sequences.
module tb_spi_mem_bridge;

  logic        clk, rst, cs_n, rx_valid, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        mem_we, mem_re, busy, err;
  logic [9:0]  mem_waddr, mem_raddr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  state;

  spi_mem_bridge #(
    .DATA_W (32),
    .ADDR_W (10),
    .RD_LAT (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with one cycle read latency.
  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  // Strobe logs, sampled mid-cycle.
  logic [9:0]  we_a_q[$];
  logic [31:0] we_d_q[$];
  logic [9:0]  re_a_q[$];
  logic [7:0]  tx_q[$];
  always @(negedge clk) begin
    if (mem_we) begin
      we_a_q.push_back(mem_waddr);
      we_d_q.push_back(mem_wdata);
    end
    if (mem_re) re_a_q.push_back(mem_raddr);
  end

  // SPI-slave side: takes an offered byte every third cycle.
  initial begin
    int gap;
    gap = 0;
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      if (tx_valid && !rst) begin
        if (gap >= 2) begin
          tx_q.push_back(tx_data);
          tx_ready = 1'b1;
          gap = 0;
        end else begin
          gap++;
        end
      end else begin
        gap = 0;
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [95:0]       frame;
    int                nb;
    int                n_we;
    logic [1:0][9:0]   we_a;
    logic [1:0][31:0]  we_d;
    int                n_re;
    logic [1:0][9:0]   re_a;
    int                n_tx;
    logic [63:0]       tx;
    logic              err;
  } vec_t;

  function automatic vec_t mk(input logic [95:0] f, input int nb, input int nwe,
                              input logic [9:0] wa0, input logic [31:0] wd0,
                              input logic [9:0] wa1, input logic [31:0] wd1,
                              input int nre, input logic [9:0] ra0, input logic [9:0] ra1,
                              input int ntx, input logic [63:0] tx, input logic e);
    vec_t v;
    v.frame = f;   v.nb = nb;
    v.n_we = nwe;  v.we_a[0] = wa0; v.we_d[0] = wd0; v.we_a[1] = wa1; v.we_d[1] = wd1;
    v.n_re = nre;  v.re_a[0] = ra0; v.re_a[1] = ra1;
    v.n_tx = ntx;  v.tx = tx;       v.err = e;
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    repeat (6) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic clear_logs();
    we_a_q.delete();
    we_d_q.delete();
    re_a_q.delete();
    tx_q.delete();
  endtask

  // Whole frame: bytes, bounded wait for expected tx bytes, then cs_n high.
  task automatic run_frame(input logic [95:0] f, input int nb, input int ntx);
    cs_n = 1'b0;
    for (int k = 0; k < nb; k++) send_byte(f[95 - 8 * k -: 8]);
    for (int k = 0; k < 400 && tx_q.size() < ntx; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = mk(96'h01_00_10_01_DE_AD_BE_EF_01_02_03_04, 12,
                 2, 10'h010, 32'hDEADBEEF, 10'h011, 32'h01020304,
                 0, 10'h0, 10'h0, 0, 64'h0, 1'b0);
    vecs[1] = mk(96'h02_00_10_01_00_00_00_00_00_00_00_00, 12,
                 0, 10'h0, 32'h0, 10'h0, 32'h0,
                 2, 10'h010, 10'h011, 8, 64'hDEADBEEF_01020304, 1'b0);
    vecs[2] = mk(96'h01_03_FF_01_11_22_33_44_55_66_77_88, 12,
                 2, 10'h3FF, 32'h11223344, 10'h000, 32'h55667788,
                 0, 10'h0, 10'h0, 0, 64'h0, 1'b0);
    vecs[3] = mk({32'h02_FF_FF_00, 64'h0}, 8,
                 0, 10'h0, 32'h0, 10'h0, 32'h0,
                 1, 10'h3FF, 10'h0, 4, {32'h11223344, 32'h0}, 1'b0);
    vecs[4] = mk({8'h7E, 88'h0}, 1,
                 0, 10'h0, 32'h0, 10'h0, 32'h0, 0, 10'h0, 10'h0, 0, 64'h0, 1'b1);
    vecs[5] = mk({8'h03, 88'h0}, 1,
                 0, 10'h0, 32'h0, 10'h0, 32'h0, 0, 10'h0, 10'h0, 1, {8'h80, 56'h0}, 1'b1);
    vecs[6] = mk({8'h04, 88'h0}, 1,
                 0, 10'h0, 32'h0, 10'h0, 32'h0, 0, 10'h0, 10'h0, 0, 64'h0, 1'b0);
    vecs[7] = mk({8'h03, 88'h0}, 1,
                 0, 10'h0, 32'h0, 10'h0, 32'h0, 0, 10'h0, 10'h0, 1, 64'h0, 1'b0);
    vecs[8] = mk({64'h01_01_23_00_CA_FE_BA_BE, 32'h0}, 8,
                 1, 10'h123, 32'hCAFEBABE, 10'h0, 32'h0,
                 0, 10'h0, 10'h0, 0, 64'h0, 1'b0);

    rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst state",    64'(state), 64'h0);
    chk("rst busy",     64'(busy), 64'h0);
    chk("rst err",      64'(err), 64'h0);
    chk("rst tx_valid", 64'(tx_valid), 64'h0);
    chk("rst tx_data",  64'(tx_data), 64'h0);
    chk("rst mem_we",   64'(mem_we), 64'h0);
    chk("rst mem_re",   64'(mem_re), 64'h0);
    chk("rst wdata",    64'(mem_wdata), 64'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      clear_logs();
      run_frame(vecs[i].frame, vecs[i].nb, vecs[i].n_tx);
      chk($sformatf("v%0d n_we", i), 64'(we_a_q.size()), 64'(vecs[i].n_we));
      for (int j = 0; j < vecs[i].n_we && j < we_a_q.size(); j++) begin
        chk($sformatf("v%0d waddr%0d", i, j), 64'(we_a_q[j]), 64'(vecs[i].we_a[j]));
        chk($sformatf("v%0d wdata%0d", i, j), 64'(we_d_q[j]), 64'(vecs[i].we_d[j]));
      end
      chk($sformatf("v%0d n_re", i), 64'(re_a_q.size()), 64'(vecs[i].n_re));
      for (int j = 0; j < vecs[i].n_re && j < re_a_q.size(); j++)
        chk($sformatf("v%0d raddr%0d", i, j), 64'(re_a_q[j]), 64'(vecs[i].re_a[j]));
      chk($sformatf("v%0d n_tx", i), 64'(tx_q.size()), 64'(vecs[i].n_tx));
      for (int j = 0; j < vecs[i].n_tx && j < tx_q.size(); j++)
        chk($sformatf("v%0d tx%0d", i, j), 64'(tx_q[j]), 64'(vecs[i].tx[63 - 8 * j -: 8]));
      chk($sformatf("v%0d err", i), 64'(err), 64'(vecs[i].err));
      chk($sformatf("v%0d idle", i), 64'(state), 64'h0);
    end

    // Abort after 2 of 4 data bytes.
    clear_logs();
    cs_n = 1'b0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    chk("abort wdata state", 64'(state), 64'h4);
    repeat (2) @(posedge clk);
    #1;
    cs_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort idle", 64'(state), 64'h0);
    repeat (3) @(posedge clk);
    #1;

    // cs_n rising with the last byte of a word: byte dropped, nothing written.
    cs_n = 1'b0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    repeat (6) @(posedge clk);
    #1;
    rx_data = 8'hDD; rx_valid = 1'b1; cs_n = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("collide idle", 64'(state), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort n_we", 64'(we_a_q.size()), 64'h0);

    // Next frame after the aborts behaves normally.
    clear_logs();
    run_frame({64'h01_00_20_00_12_34_56_78, 32'h0}, 8, 0);
    chk("post-abort n_we", 64'(we_a_q.size()), 64'h1);
    if (we_a_q.size() > 0) begin
      chk("post-abort waddr", 64'(we_a_q[0]), 64'h020);
      chk("post-abort wdata", 64'(we_d_q[0]), 64'h12345678);
    end

    // Asynchronous reset while the first word's write strobe is high.
    clear_logs();
    cs_n = 1'b0;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h30); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("pre-rst mem_we", 64'(mem_we), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst state",  64'(state), 64'h0);
    chk("async rst busy",   64'(busy), 64'h0);
    chk("async rst mem_we", 64'(mem_we), 64'h0);
    chk("async rst waddr",  64'(mem_waddr), 64'h0);
    chk("async rst wdata",  64'(mem_wdata), 64'h0);
    chk("async rst tx",     64'(tx_valid), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst n_we", 64'(we_a_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
